// File: rtl/axi_rd_arbiter.sv
// Two-master, one-slave AXI4 read arbiter: round-robin AR grant, one burst in flight,
// master index folded into the slave ID, R beats routed back by the registered grant.
//
//   state | meaning
//   IDLE  | no burst in flight; pick the next master
//   ADDR  | granted master's AR passed through to the slave
//   DATA  | slave R beats routed to the granted master until rlast
module axi_rd_arbiter #(
    parameter int ID_WIDTH   = 4,
    parameter int IDS_WIDTH  = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 4,
    localparam int MAR_W = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + 5,
    localparam int SAR_W = IDS_WIDTH + ADDR_WIDTH + LEN_WIDTH + 5,
    localparam int MR_W  = ID_WIDTH + DATA_WIDTH + 3,
    localparam int SR_W  = IDS_WIDTH + DATA_WIDTH + 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*MAR_W-1:0] m_ar,
    input  logic [1:0]         m_arvalid,
    output logic [1:0]         m_arready,
    output logic [MR_W-1:0]    m_r,
    output logic [1:0]         m_rvalid,
    input  logic [1:0]         m_rready,
    output logic [SAR_W-1:0]   s_ar,
    output logic               s_arvalid,
    input  logic               s_arready,
    input  logic [SR_W-1:0]    s_r,
    input  logic               s_rvalid,
    output logic               s_rready,
    output logic               rd_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t               state;
    logic                 gnt;
    logic                 last_gnt;
    logic [LEN_WIDTH-1:0] beat_cnt;

    logic [MAR_W-1:0]     sel_ar;
    logic [LEN_WIDTH-1:0] sel_len;
    logic [IDS_WIDTH-1:0] sid;
    logic                 s_rlast;
    logic                 ar_hs;
    logic                 r_hs;
    logic                 unused_sid;

    assign sel_ar  = gnt ? m_ar[2*MAR_W-1:MAR_W] : m_ar[MAR_W-1:0];
    assign sel_len = sel_ar[5 +: LEN_WIDTH];
    assign s_rlast = s_r[0];

    // Upper slave ID bits (master index, padding) are not needed on return.
    assign unused_sid = ^s_r[SR_W-1:MR_W];

    always_comb begin
        sid                 = '0;
        sid[ID_WIDTH]       = gnt;
        sid[ID_WIDTH-1:0]   = sel_ar[MAR_W-1 -: ID_WIDTH];
    end

    assign ar_hs = (state == ADDR) && m_arvalid[gnt] && s_arready;
    assign r_hs  = (state == DATA) && s_rvalid && m_rready[gnt];

    always_comb begin
        m_arready = '0;
        s_arvalid = 1'b0;
        s_ar      = '0;
        m_rvalid  = '0;
        s_rready  = 1'b0;
        m_r       = '0;
        case (state)
            ADDR: begin
                s_arvalid      = m_arvalid[gnt];
                m_arready[gnt] = s_arready;
                s_ar           = {sid, sel_ar[MAR_W-ID_WIDTH-1:0]};
            end
            DATA: begin
                m_rvalid[gnt] = s_rvalid;
                s_rready      = m_rready[gnt];
                m_r           = s_r[MR_W-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
            beat_cnt <= '0;
            rd_err   <= 1'b0;
        end else begin
            rd_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (|m_arvalid) begin
                        gnt   <= (&m_arvalid) ? ~last_gnt : m_arvalid[1];
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (ar_hs) begin
                        beat_cnt <= sel_len;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        if (beat_cnt != '0)
                            beat_cnt <= beat_cnt - LEN_WIDTH'(1);
                        // Flags both an early rlast and a missing one; exit still waits for rlast.
                        rd_err <= (s_rlast != (beat_cnt == '0));
                        if (s_rlast) begin
                            last_gnt <= gnt;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: behavioural masters and slave, a scoreboard of expected
// transactions in grant order, a vector table plus hand-written corner sequences.
module tb_axi_rd_arbiter;
    localparam int IDW   = 4;
    localparam int IDSW  = 8;
    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int LW    = 4;
    localparam int MAR_W = IDW + AW + LW + 5;
    localparam int SAR_W = IDSW + AW + LW + 5;
    localparam int MR_W  = IDW + DW + 3;
    localparam int SR_W  = IDSW + DW + 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [2*MAR_W-1:0] m_ar;
    logic [1:0]         m_arvalid;
    logic [1:0]         m_arready;
    logic [MR_W-1:0]    m_r;
    logic [1:0]         m_rvalid;
    logic [1:0]         m_rready;
    logic [SAR_W-1:0]   s_ar;
    logic               s_arvalid;
    logic               s_arready;
    logic [SR_W-1:0]    s_r;
    logic               s_rvalid;
    logic               s_rready;
    logic               rd_err;

    axi_rd_arbiter #(
        .ID_WIDTH(IDW), .IDS_WIDTH(IDSW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst(rst),
        .m_ar(m_ar), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_r(m_r), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .s_ar(s_ar), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_r(s_r), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    // lat_kind: 0 none, 1 = one cycle after request, 2 = two cycles after previous last beat
    typedef struct {
        int             m;
        logic [IDW-1:0] id;
        logic [AW-1:0]  addr;
        logic [LW-1:0]  len;
        int             short_at;
        logic [IDSW-1:0] exp_sid;
        int             exp_errs;
        int             lat_kind;
    } txn_t;

    txn_t             exp_q[$];
    logic [MAR_W-1:0] mq0[$];
    logic [MAR_W-1:0] mq1[$];
    int checks = 0, errors = 0;
    int cyc = 0, last_r_cyc = 0, mbeat = 0, rcount = 0, err_cnt = 0, stall_cnt = 0;
    int pres_cyc[2];
    logic [1:0] mhs;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [MAR_W-1:0] pay(input txn_t t);
        return {t.id, t.addr, t.len, 3'd2, 2'b01};
    endfunction

    task automatic issue(input txn_t t);
        exp_q.push_back(t);
        if (t.m == 0) mq0.push_back(pay(t));
        else          mq1.push_back(pay(t));
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((exp_q.size() > 0 || mq0.size() > 0 || mq1.size() > 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d transactions outstanding, expected 0", exp_q.size());
            exp_q.delete();
            mq0.delete();
            mq1.delete();
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ctl"}, {57'd0, m_arready, m_rvalid, s_arvalid, s_rready, rd_err}, 64'd0);
        chk({tag, "_m_r"}, 64'(m_r), 64'd0);
        chk({tag, "_s_ar"}, 64'(s_ar), 64'd0);
    endtask

    task automatic wait_beats(input int target);
        int n = 0;
        while (rcount < target && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (rcount < target) begin
            checks++;
            errors++;
            $display("FAIL beat_wait: got %0d beats expected %0d", rcount, target);
        end
    endtask

    // Masters: present queued requests, drop/replace on handshake.
    initial begin : masters
        m_arvalid = '0;
        m_ar      = '0;
        forever begin
            @(negedge clk);
            mhs = m_arvalid & m_arready;
            @(posedge clk);
            #1;
            if (rst) begin
                m_arvalid = '0;
            end else begin
                if (mhs[0]) m_arvalid[0] = 1'b0;
                if (mhs[1]) m_arvalid[1] = 1'b0;
                if (!m_arvalid[0] && mq0.size() > 0) begin
                    m_ar[MAR_W-1:0] = mq0.pop_front();
                    m_arvalid[0]    = 1'b1;
                    pres_cyc[0]     = cyc;
                end
                if (!m_arvalid[1] && mq1.size() > 0) begin
                    m_ar[2*MAR_W-1:MAR_W] = mq1.pop_front();
                    m_arvalid[1]          = 1'b1;
                    pres_cyc[1]           = cyc;
                end
            end
        end
    end

    // Slave: accepts AR, returns beats {junk|id, addr, sid, beat, resp, last}.
    initial begin : slave
        logic [IDSW-1:0] sid;
        logic [AW-1:0]   saddr;
        logic [LW-1:0]   slen;
        int              sbeat;
        int              last_idx;
        logic            busy, ahs, rhs;
        s_arready = 1'b1;
        s_rvalid  = 1'b0;
        s_r       = '0;
        busy      = 1'b0;
        sbeat     = 0;
        last_idx  = 0;
        sid       = '0;
        saddr     = '0;
        slen      = '0;
        forever begin
            @(negedge clk);
            ahs = s_arvalid && s_arready;
            rhs = s_rvalid && s_rready;
            if (ahs) {sid, saddr, slen} = s_ar[SAR_W-1:5];
            @(posedge clk);
            #1;
            if (rst) begin
                busy = 1'b0;
            end else begin
                if (rhs) begin
                    if (s_r[0]) busy = 1'b0;
                    sbeat++;
                end
                if (ahs) begin
                    busy     = 1'b1;
                    sbeat    = 0;
                    last_idx = (exp_q.size() > 0 && exp_q[0].short_at > 0) ? exp_q[0].short_at - 1 : int'(slen);
                end
            end
            s_rvalid = busy;
            s_r = busy ? {4'b1010, sid[3:0], saddr, sid, 8'(sbeat), 2'(sbeat), 1'(sbeat == last_idx)} : '0;
        end
    end

    // Scoreboard monitor.
    initial begin : monitor
        txn_t t;
        int   li;
        forever begin
            @(negedge clk);
            if (!rst) begin
                err_cnt += int'(rd_err);
                if (s_arvalid && s_arready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ar: got s_ar %h expected no request", s_ar);
                    end else begin
                        t = exp_q[0];
                        chk("s_ar", 64'(s_ar), 64'({t.exp_sid, t.addr, t.len, 3'd2, 2'b01}));
                        if (t.lat_kind == 1) chk("ar_latency", 64'(cyc - pres_cyc[t.m]), 64'd1);
                        if (t.lat_kind == 2) chk("regrant_latency", 64'(cyc - last_r_cyc), 64'd2);
                        mbeat = 0;
                    end
                end
                if (s_rvalid && exp_q.size() > 0)
                    chk("s_rready", 64'(s_rready), 64'(m_rready[exp_q[0].m]));
                if (s_rvalid && !s_rready) stall_cnt++;
                if (|(m_rvalid & m_rready)) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_r: got m_rvalid %b expected 00", m_rvalid);
                    end else begin
                        t  = exp_q[0];
                        li = (t.short_at > 0) ? t.short_at - 1 : int'(t.len);
                        chk("m_rvalid", 64'(m_rvalid), 64'(2'b01 << t.m));
                        chk("m_r", 64'(m_r),
                            64'({t.id, t.addr, t.exp_sid, 8'(mbeat), 2'(mbeat), 1'(mbeat == li)}));
                        rcount++;
                        if (mbeat == li) begin
                            void'(exp_q.pop_front());
                            last_r_cyc = cyc;
                        end
                        mbeat++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        txn_t vecs[5];
        txn_t t;
        int   base;
        vecs[0] = '{0, 4'h3, 16'h0010, 4'd1,  0, 8'h03, 0, 1};
        vecs[1] = '{1, 4'h7, 16'hBEEF, 4'd0,  0, 8'h17, 0, 1};
        vecs[2] = '{0, 4'hF, 16'h1234, 4'd3,  2, 8'h0F, 1, 1};
        vecs[3] = '{1, 4'h0, 16'hFFFF, 4'd1,  3, 8'h10, 1, 1};
        vecs[4] = '{0, 4'hA, 16'h0000, 4'd15, 0, 8'h0A, 0, 1};

        rst      = 1'b1;
        m_rready = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        #1 rst = 1'b0;
        @(negedge clk);
        #1;

        // Simultaneous request after reset: m0 first, then m1.
        issue('{0, 4'h2, 16'h2000, 4'd1, 0, 8'h02, 0, 1});
        issue('{1, 4'h5, 16'h3000, 4'd2, 0, 8'h15, 0, 2});
        wait_done(200);

        for (int i = 0; i < 5; i++) begin
            err_cnt = 0;
            issue(vecs[i]);
            wait_done(200);
            chk($sformatf("rd_err_pulses_v%0d", i), 64'(err_cnt), 64'(vecs[i].exp_errs));
        end

        // Both masters hold arvalid for 4 bursts; last grant was m0, so m1 leads.
        err_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            t.m        = (k % 2 == 0) ? 1 : 0;
            t.id       = 4'(k + 4);
            t.addr     = 16'(16'h0100 * k);
            t.len      = 4'(k % 3);
            t.short_at = 0;
            t.exp_sid  = {3'b000, 1'(t.m), t.id};
            t.exp_errs = 0;
            t.lat_kind = (k == 0) ? 1 : 2;
            issue(t);
        end
        wait_done(400);
        chk("rd_err_fair", 64'(err_cnt), 64'd0);

        // m0 R back-pressure for 3 cycles mid-burst; m1 ready low must not matter.
        stall_cnt = 0;
        m_rready[1] = 1'b0;
        base = rcount;
        issue('{0, 4'h9, 16'h4444, 4'd3, 0, 8'h09, 0, 1});
        wait_beats(base + 1);
        @(posedge clk);
        #1 m_rready[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 m_rready[0] = 1'b1;
        wait_done(200);
        m_rready[1] = 1'b1;
        chk("stall_cycles", 64'(stall_cnt), 64'd3);

        // Reset mid-DATA, then a tie must go to m0 again.
        base = rcount;
        issue('{1, 4'h6, 16'h5555, 4'd7, 0, 8'h16, 0, 1});
        wait_beats(base + 2);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk_idle("mid_reset");
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        issue('{0, 4'hC, 16'h6000, 4'd1, 0, 8'h0C, 0, 1});
        issue('{1, 4'hD, 16'h7000, 4'd0, 0, 8'h1D, 0, 2});
        wait_done(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
